// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF1 program-counter sequencing and instruction-fetch control.
// Chooses when the PC loads and with what value (boot vector, PC+4, branch
// target or trap vector). It also runs a single-outstanding request/response
// handshake with instruction memory, and discards responses made stale by a
// redirect.
// Optional build macro: PC_FETCH_PERF_EN adds fetch_count / stall_count
// performance counters.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter int unsigned BOOT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc_if1,
  output logic        pc_en,
  output logic [31:0] next_pc_if1,
  input  logic        stall_if,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        halted
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  // Redirect targets are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [1:0]  state_r, state_nxt_s;
  logic [7:0]  boot_cnt_r, boot_cnt_nxt_s;
  logic        kill_r, kill_nxt_s;
  logic        halt_pend_r, halt_pend_nxt_s;
  logic [31:0] pend_target_r, pend_target_nxt_s;
  logic [31:0] fetch_pc_r, fetch_pc_nxt_s;
  logic        redir_s;
  logic [31:0] redir_target_s;
  logic [31:0] seq_pc_s;

  assign imem_addr = current_pc_if1;
  assign fetch_pc  = fetch_pc_r;

  // Redirect decode: the trap has priority over the branch; also sequential PC+4.
  always_comb begin
    redir_s  = trap_req | branch_taken;
    seq_pc_s = current_pc_if1 + 32'd4;
    if (trap_req) begin
      redir_target_s = word_align(trap_vector);
    end else if (branch_taken) begin
      redir_target_s = word_align(branch_target);
    end else begin
      redir_target_s = 32'h0000_0000;
    end
  end

  // FSM next-state and combinational outputs; everything idles while reset is high.
  always_comb begin
    pc_en             = 1'b0;
    next_pc_if1       = 32'h0000_0000;
    imem_req          = 1'b0;
    fetch_valid       = 1'b0;
    halted            = 1'b0;
    state_nxt_s       = state_r;
    boot_cnt_nxt_s    = boot_cnt_r;
    kill_nxt_s        = kill_r;
    halt_pend_nxt_s   = halt_pend_r;
    pend_target_nxt_s = pend_target_r;
    fetch_pc_nxt_s    = fetch_pc_r;
    if (reset) begin
      state_nxt_s = ST_BOOT;
    end else begin
      case (state_r)
        ST_BOOT: begin
          // Load the boot vector once, then wait out the remaining boot cycles.
          if (boot_cnt_r == 8'd0) begin
            pc_en       = 1'b1;
            next_pc_if1 = RESET_VECTOR;
          end else begin
            pc_en = 1'b0;
          end
          if (boot_cnt_r == BOOT_LAST) begin
            state_nxt_s    = ST_REQ;
            boot_cnt_nxt_s = 8'd0;
          end else begin
            boot_cnt_nxt_s = boot_cnt_r + 8'd1;
          end
        end
        ST_REQ: begin
          if (redir_s) begin
            pc_en       = 1'b1;
            next_pc_if1 = redir_target_s;
          end else if (halt_req) begin
            state_nxt_s = ST_HALT;
          end else if (stall_if) begin
            imem_req = 1'b0;
          end else begin
            imem_req = 1'b1;
            if (imem_gnt) begin
              state_nxt_s = ST_WAIT;
            end else begin
              state_nxt_s = ST_REQ;
            end
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            // A response that was overtaken by a redirect is dropped.
            if (kill_r || redir_s) begin
              pc_en       = 1'b1;
              next_pc_if1 = redir_s ? redir_target_s : pend_target_r;
            end else begin
              fetch_valid    = 1'b1;
              fetch_pc_nxt_s = current_pc_if1;
              pc_en          = 1'b1;
              next_pc_if1    = seq_pc_s;
            end
            kill_nxt_s      = 1'b0;
            halt_pend_nxt_s = 1'b0;
            state_nxt_s     = (halt_pend_r || halt_req) ? ST_HALT : ST_REQ;
          end else begin
            // Remember the latest redirect until the outstanding response returns.
            if (redir_s) begin
              pend_target_nxt_s = redir_target_s;
              kill_nxt_s        = 1'b1;
            end else begin
              kill_nxt_s = kill_r;
            end
            if (halt_req) begin
              halt_pend_nxt_s = 1'b1;
            end else begin
              halt_pend_nxt_s = halt_pend_r;
            end
          end
        end
        ST_HALT: begin
          halted = 1'b1;
          if (trap_req) begin
            pc_en       = 1'b1;
            next_pc_if1 = word_align(trap_vector);
            state_nxt_s = ST_REQ;
          end else if (resume_req) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        default: begin
          state_nxt_s = ST_BOOT;
        end
      endcase
    end
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_BOOT;
      boot_cnt_r    <= 8'd0;
      kill_r        <= 1'b0;
      halt_pend_r   <= 1'b0;
      pend_target_r <= 32'h0000_0000;
      fetch_pc_r    <= 32'h0000_0000;
    end else begin
      state_r       <= state_nxt_s;
      boot_cnt_r    <= boot_cnt_nxt_s;
      kill_r        <= kill_nxt_s;
      halt_pend_r   <= halt_pend_nxt_s;
      pend_target_r <= pend_target_nxt_s;
      fetch_pc_r    <= fetch_pc_nxt_s;
    end
  end

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count_r;
  logic [31:0] stall_count_r;

  assign fetch_count = fetch_count_r;
  assign stall_count = stall_count_r;

  // Performance counters: delivered fetches and stalled request cycles (wrap at 2^32).
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_r <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (fetch_valid) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      if ((state_r == ST_REQ) && stall_if && !redir_s) begin
        stall_count_r <= stall_count_r + 32'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end
`endif

endmodule
